inst_fetch_resp: RTL and testbench

INST_FETCH_RESP -- requirements
Module: inst_fetch_resp

---
 rtl/inst_fetch_resp_if.sv | 26 ++
 rtl/inst_fetch_resp.sv | 143 ++++++++++++++
 tb/tb_inst_fetch_resp.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_resp_if.sv
// Fetch request/response and byte-memory signals between the PC stage,
// the fetch responder and the byte-wide instruction memory.
interface inst_fetch_resp_if;
  logic        ce_i;
  logic [31:0] addr_i;
  logic        flush_i;
  logic        busy_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        misalign_o;
  logic [31:0] mem_addr_o;
  logic        mem_rd_o;
  logic [7:0]  mem_din_i;

  // Responder side.
  modport slave (
    input  ce_i, addr_i, flush_i, mem_din_i,
    output busy_o, inst_o, inst_valid_o, misalign_o, mem_addr_o, mem_rd_o
  );

  // Requester / memory side.
  modport master (
    output ce_i, addr_i, flush_i, mem_din_i,
    input  busy_o, inst_o, inst_valid_o, misalign_o, mem_addr_o, mem_rd_o
  );
endinterface

// File: rtl/inst_fetch_resp.sv
// Instruction fetch responder: assembles a 32-bit little-endian word from four
// reads of a byte-wide memory, with a one-entry word buffer for repeat fetches.
module inst_fetch_resp (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_resp_if.slave    bus_io
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] asm_q, asm_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_tag_q, buf_tag_d;
  logic [31:0] buf_word_q, buf_word_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        misalign_q, misalign_d;
  logic        mem_rd_q, mem_rd_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic busy;
  logic accept;
  logic misaligned;
  logic hit;

  assign busy       = (state_q != StIdle);
  assign accept     = bus_io.ce_i && !busy && !bus_io.flush_i;
  assign misaligned = (bus_io.addr_i[1:0] != 2'b00);
  assign hit        = buf_valid_q && (buf_tag_q == bus_io.addr_i);

  // State and datapath registers; reset dominates everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 2'd0;
      addr_q       <= 32'd0;
      asm_q        <= 32'd0;
      buf_valid_q  <= 1'b0;
      buf_tag_q    <= 32'd0;
      buf_word_q   <= 32'd0;
      inst_q       <= 32'd0;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      asm_q        <= asm_d;
      buf_valid_q  <= buf_valid_d;
      buf_tag_q    <= buf_tag_d;
      buf_word_q   <= buf_word_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      misalign_q   <= misalign_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // Next-state: only an aligned buffer miss leaves IDLE; flush always returns.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && !misaligned && !hit) state_d = StIssue;
      end
      StIssue: begin
        if (bus_io.flush_i)    state_d = StIdle;
        else if (cnt_q == 2'd3) state_d = StDrain;
      end
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs and datapath next values.
  always_comb begin
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    asm_d        = asm_q;
    buf_valid_d  = buf_valid_q;
    buf_tag_d    = buf_tag_q;
    buf_word_d   = buf_word_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    misalign_d   = 1'b0;
    mem_rd_d     = mem_rd_q;
    mem_addr_d   = mem_addr_q;
    if (bus_io.flush_i) begin
      buf_valid_d = 1'b0;
      mem_rd_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (misaligned) begin
              misalign_d = 1'b1;
            end else if (hit) begin
              inst_d       = buf_word_q;
              inst_valid_d = 1'b1;
            end else begin
              addr_d     = bus_io.addr_i;
              mem_addr_d = bus_io.addr_i;
              mem_rd_d   = 1'b1;
              cnt_d      = 2'd0;
            end
          end
        end
        StIssue: begin
          // Read data lags the address by one cycle, so shifting starts at cnt 1.
          if (cnt_q != 2'd0) asm_d = {bus_io.mem_din_i, asm_q[31:8]};
          if (cnt_q == 2'd3) begin
            mem_rd_d = 1'b0;
          end else begin
            mem_addr_d = mem_addr_q + 32'd1;
            cnt_d      = cnt_q + 2'd1;
          end
        end
        StDrain: begin
          inst_d       = {bus_io.mem_din_i, asm_q[31:8]};
          inst_valid_d = 1'b1;
          buf_valid_d  = 1'b1;
          buf_tag_d    = addr_q;
          buf_word_d   = {bus_io.mem_din_i, asm_q[31:8]};
        end
        default: ;
      endcase
    end
  end

  assign bus_io.busy_o       = busy;
  assign bus_io.inst_o       = inst_q;
  assign bus_io.inst_valid_o = inst_valid_q;
  assign bus_io.misalign_o   = misalign_q;
  assign bus_io.mem_addr_o   = mem_addr_q;
  assign bus_io.mem_rd_o     = mem_rd_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: directed scenarios plus randomized requests with
// random flush/reset injection, checked against a transaction-level model.
module tb_inst_fetch_resp;

  logic clk = 1'b0;
  logic rst;

  inst_fetch_resp_if bus ();

  inst_fetch_resp dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem_pre [logic [31:0]];
  logic [31:0] reads [$];

  // Model state: the one-entry buffer and the value inst_o should hold.
  bit          mdl_valid;
  logic [31:0] mdl_tag;
  logic [31:0] mdl_word;
  logic [31:0] exp_inst;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (mem_pre.exists(a)) return mem_pre[a];
    return 8'(a * 32'd37 + (a >> 9) + 32'd5);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  // Byte memory with one cycle of read latency; also logs every read address.
  always @(posedge clk) begin
    bus.mem_din_i <= (bus.mem_rd_o === 1'b1) ? mem_byte(bus.mem_addr_o) : 8'($urandom);
    if (bus.mem_rd_o === 1'b1) reads.push_back(bus.mem_addr_o);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy_o !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) check_eq("busy_timeout", 32'(bus.busy_o), 32'd0);
  endtask

  // One request presented for a single edge; abort_at (1..5) injects flush or
  // reset before that edge counted from the request edge, 0 means none.
  task automatic run_req(input logic [31:0] a, input int abort_at, input bit use_rst);
    int          kind;  // 0 misaligned, 1 hit, 2 miss
    int          n_exp;
    logic [31:0] word;
    bit          aborted;
    logic        e_busy, e_rd, e_valid, e_mis;
    wait_idle();
    word = mem_word(a);
    if (a[1:0] != 2'b00)                kind = 0;
    else if (mdl_valid && mdl_tag == a) kind = 1;
    else                                kind = 2;
    reads.delete();
    bus.ce_i   = 1'b1;
    bus.addr_i = a;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      aborted = (abort_at != 0) && (k >= abort_at);
      if (abort_at != 0 && k == abort_at) begin
        mdl_valid = 1'b0;
        if (use_rst) exp_inst = 32'd0;
      end
      e_busy = 1'b0; e_rd = 1'b0; e_valid = 1'b0; e_mis = 1'b0;
      if (kind == 0 && k == 0) e_mis = 1'b1;
      if (kind == 1 && k == 0) begin
        e_valid  = 1'b1;
        exp_inst = mdl_word;
      end
      if (kind == 2 && !aborted) begin
        if (k <= 3) begin
          e_busy = 1'b1;
          e_rd   = 1'b1;
          check_eq("mem_addr", bus.mem_addr_o, a + 32'(k));
        end else if (k == 4) begin
          e_busy = 1'b1;
        end else if (k == 5) begin
          e_valid   = 1'b1;
          exp_inst  = word;
          mdl_valid = 1'b1;
          mdl_tag   = a;
          mdl_word  = word;
        end
      end
      if (use_rst && abort_at != 0 && k == abort_at) check_eq("rst_mem_addr", bus.mem_addr_o, 32'd0);
      check_eq("busy", 32'(bus.busy_o), 32'(e_busy));
      check_eq("mem_rd", 32'(bus.mem_rd_o), 32'(e_rd));
      check_eq("inst_valid", 32'(bus.inst_valid_o), 32'(e_valid));
      check_eq("misalign", 32'(bus.misalign_o), 32'(e_mis));
      check_eq("inst", bus.inst_o, exp_inst);
      bus.ce_i    = 1'b0;
      bus.flush_i = (abort_at == k + 1) && !use_rst;
      rst         = (abort_at == k + 1) && use_rst;
    end
    if (kind != 2)         n_exp = 0;
    else if (abort_at == 0) n_exp = 4;
    else                   n_exp = (abort_at < 4) ? abort_at : 4;
    check_eq("read_count", 32'(reads.size()), 32'(n_exp));
    for (int i = 0; i < reads.size() && i < n_exp; i++)
      check_eq("read_addr", reads[i], a + 32'(i));
  endtask

  // ce_i held high across two sequential fetches.
  task automatic run_back_to_back();
    int t_pulse [2];
    int pulses = 0;
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    mdl_valid   = 1'b0;
    t_pulse[0]  = -1;
    t_pulse[1]  = -1;
    bus.ce_i    = 1'b1;
    bus.addr_i  = 32'h0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.inst_valid_o === 1'b1 && pulses < 2) begin
        t_pulse[pulses] = c;
        check_eq("b2b_word", bus.inst_o, mem_word(32'(pulses * 4)));
        pulses++;
        if (pulses == 1) bus.addr_i = 32'h4;
        else             bus.ce_i   = 1'b0;
      end
    end
    bus.ce_i = 1'b0;
    check_eq("b2b_pulses", 32'(pulses), 32'd2);
    check_eq("b2b_gap", 32'(t_pulse[1] - t_pulse[0]), 32'd6);
    mdl_valid = 1'b1;
    mdl_tag   = 32'h4;
    mdl_word  = mem_word(32'h4);
    exp_inst  = mem_word(32'h4);
  endtask

  initial begin
    logic [31:0] pool [4];
    logic [31:0] a;
    int          r;
    int          ab;
    pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200; pool[3] = 32'hFFFF_FFFC;
    mem_pre[32'h100] = 8'h13;
    mem_pre[32'h101] = 8'h05;
    mem_pre[32'h102] = 8'h10;
    mem_pre[32'h103] = 8'h00;

    rst         = 1'b1;
    bus.ce_i    = 1'b0;
    bus.flush_i = 1'b0;
    bus.addr_i  = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("reset_busy", 32'(bus.busy_o), 32'd0);
    check_eq("reset_valid", 32'(bus.inst_valid_o), 32'd0);
    check_eq("reset_misalign", 32'(bus.misalign_o), 32'd0);
    check_eq("reset_mem_rd", 32'(bus.mem_rd_o), 32'd0);
    check_eq("reset_inst", bus.inst_o, 32'd0);
    check_eq("reset_mem_addr", bus.mem_addr_o, 32'd0);
    rst       = 1'b0;
    mdl_valid = 1'b0;
    exp_inst  = 32'd0;

    run_req(32'h100, 0, 1'b0);                 // miss
    check_eq("miss_word_0x100", bus.inst_o, 32'h0010_0513);
    run_req(32'h100, 0, 1'b0);                 // hit
    run_req(32'h200, 2, 1'b0);                 // flush mid-fetch
    run_req(32'h100, 0, 1'b0);                 // buffer was invalidated -> miss
    run_req(32'h102, 0, 1'b0);                 // misaligned
    run_req(32'hFFFF_FFFC, 0, 1'b0);           // address wrap
    run_req(32'h300, 3, 1'b1);                 // reset mid-fetch
    run_back_to_back();

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      a = pool[$urandom_range(0, 3)];
      else if (r < 8) a = {$urandom() >> 2, 2'b00};
      else            a = {$urandom() >> 2, 2'(($urandom_range(1, 3)))};
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      run_req(a, ab, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
